// File: rtl/dram_dump_if.sv
// Bus bundle for dram_dump: control/status, DRAM read port and output stream.
interface dram_dump_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;
  logic              dram_req;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, base, len, dram_q, out_ready,
    output busy, done, dram_req, dram_addr, out_data, out_valid
  );

  modport slave (
    output start, base, len, dram_q, out_ready,
    input  busy, done, dram_req, dram_addr, out_data, out_valid
  );
endinterface

// File: rtl/dram_dump.sv
// Streams a DRAM region [base, base+len) out over a valid/ready port, one word per
// READ/CAPT/OUT pass, borrowing the DRAM address port only while reading.
module dram_dump #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic       Clk,
  input  logic       RST_n,
  dram_dump_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              dram_req;
  logic              busy;
  logic              done;
  logic              out_valid_d;
  logic              dram_req_d;
  logic              busy_d;
  logic              done_d;

  // State register; status outputs are registered from the next-state decode.
  always_ff @(posedge Clk) begin
    if (!RST_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      dram_req  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= out_valid_d;
      dram_req  <= dram_req_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = (bus.len != '0) ? READ : DONE;
      READ: state_next = CAPT;
      CAPT: state_next = OUT;
      OUT:  if (bus.out_ready) state_next = (remaining == ADDR_W'(1)) ? DONE : READ;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    dram_req_d  = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    case (state_next)
      IDLE:    busy_d      = 1'b0;
      READ:    dram_req_d  = 1'b1;
      CAPT:    dram_req_d  = 1'b1;
      OUT:     out_valid_d = 1'b1;
      DONE:    done_d      = 1'b1;
      default: busy_d      = 1'b0;
    endcase
  end

  // Address/remaining counters and output word capture.
  always_ff @(posedge Clk) begin
    if (!RST_n) begin
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && (bus.len != '0)) begin
            addr      <= bus.base;
            remaining <= bus.len;
          end
        end
        CAPT: out_data <= bus.dram_q;
        OUT: begin
          if (bus.out_ready) begin
            remaining <= remaining - ADDR_W'(1);
            if (remaining != ADDR_W'(1)) addr <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dram_addr = addr;
  assign bus.dram_req  = dram_req;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_dram_dump.sv
// Directed bench for dram_dump with a registered-address DRAM model and a stream monitor.
module tb_dram_dump;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  logic Clk   = 1'b0;
  logic RST_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dram_dump_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  dram_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.Clk(Clk), .RST_n(RST_n), .bus(bus));

  always #5 Clk = ~Clk;

  logic [DATA_W-1:0] mem [256];
  always @(posedge Clk) bus.dram_q <= mem[bus.dram_addr];

  // Records accepted words, the address of each DRAM read burst, and done pulses.
  logic [DATA_W-1:0] got_data [$];
  logic [ADDR_W-1:0] got_addr [$];
  int   done_cnt = 0;
  logic req_prev = 1'b0;
  always @(posedge Clk) begin
    if (bus.out_valid && bus.out_ready) got_data.push_back(bus.out_data);
    if (bus.dram_req && !req_prev) got_addr.push_back(bus.dram_addr);
    if (bus.done) done_cnt++;
    req_prev <= bus.dram_req;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    bus.base  = b;
    bus.len   = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.out_valid, bus.done, bus.busy, bus.dram_req} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {bus.out_valid, bus.done, bus.busy, bus.dram_req});
    end
    checks++;
    if ({bus.dram_addr, bus.out_data} !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got addr=%h data=%h want 00/00", bus.dram_addr, bus.out_data);
    end
    RST_n = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int nd = got_data.size();
    int nc = done_cnt;
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;
    bus.out_ready = 1'b1;
    pulse_start(8'h10, 8'd3);
    checks++;
    if ({bus.busy, bus.dram_req, bus.out_valid, bus.dram_addr} !== {3'b110, 8'h10}) begin
      errors++; $display("FAIL basic_read: got busy/req/valid=%b addr=%h want 110 10",
                         {bus.busy, bus.dram_req, bus.out_valid}, bus.dram_addr);
    end
    tick();
    checks++;
    if ({bus.dram_req, bus.out_valid, bus.dram_addr} !== {2'b10, 8'h10}) begin
      errors++; $display("FAIL basic_capt: got req/valid=%b addr=%h want 10 10",
                         {bus.dram_req, bus.out_valid}, bus.dram_addr);
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.dram_req, bus.out_data} !== {2'b10, 8'hA1}) begin
      errors++; $display("FAIL basic_first_word: got valid/req=%b data=%h want 10 A1",
                         {bus.out_valid, bus.dram_req}, bus.out_data);
    end
    repeat (6) tick();
    checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'hC3}) begin
      errors++; $display("FAIL basic_last_word: got valid=%b data=%h want 1 C3", bus.out_valid, bus.out_data);
    end
    tick();
    checks++;
    if ({bus.done, bus.busy, bus.out_valid, bus.dram_req} !== 4'b1100) begin
      errors++; $display("FAIL basic_done: got done/busy/valid/req=%b want 1100",
                         {bus.done, bus.busy, bus.out_valid, bus.dram_req});
    end
    tick();
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL basic_idle: got done/busy=%b want 00", {bus.done, bus.busy});
    end
    checks++;
    if (got_data.size() != nd + 3 || {got_data[nd], got_data[nd+1], got_data[nd+2]} !== 24'hA1B2C3
        || done_cnt != nc + 1) begin
      errors++; $display("FAIL basic_stream: got %p done=%0d want A1 B2 C3 done=1", got_data, done_cnt - nc);
    end
  endtask

  task automatic test_wrap();
    int  nd = got_data.size();
    int  na = got_addr.size();
    bit  to;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    bus.out_ready = 1'b1;
    pulse_start(8'hFE, 8'd3);
    wait_idle(40, to);
    checks++;
    if (to) begin errors++; $display("FAIL wrap_timeout: busy=%b want 0", bus.busy); end
    checks++;
    if (got_addr.size() != na + 3 || {got_addr[na], got_addr[na+1], got_addr[na+2]} !== 24'hFEFF00) begin
      errors++; $display("FAIL wrap_addr: got %p want FE FF 00", got_addr);
    end
    checks++;
    if (got_data.size() != nd + 3 || {got_data[nd], got_data[nd+1], got_data[nd+2]} !== 24'h112233) begin
      errors++; $display("FAIL wrap_data: got %p want 11 22 33", got_data);
    end
  endtask

  task automatic test_len_zero();
    int na = got_addr.size();
    int nd = got_data.size();
    bus.out_ready = 1'b1;
    pulse_start(8'h20, 8'd0);
    checks++;
    if ({bus.done, bus.busy, bus.dram_req, bus.out_valid} !== 4'b1100) begin
      errors++; $display("FAIL len0_done: got done/busy/req/valid=%b want 1100",
                         {bus.done, bus.busy, bus.dram_req, bus.out_valid});
    end
    tick();
    checks++;
    if ({bus.done, bus.busy} !== 2'b00 || got_addr.size() != na || got_data.size() != nd) begin
      errors++; $display("FAIL len0_idle: got done/busy=%b reads=%0d words=%0d want 00 0 0",
                         {bus.done, bus.busy}, got_addr.size() - na, got_data.size() - nd);
    end
  endtask

  task automatic test_backpressure();
    int nd = got_data.size();
    int na = got_addr.size();
    int held = 0;
    bit to;
    mem[8'h30] = 8'h5C; mem[8'h31] = 8'h6D;
    bus.out_ready = 1'b0;
    pulse_start(8'h30, 8'd2);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid && bus.out_data == 8'h5C && bus.dram_addr == 8'h30 && !bus.dram_req) held++;
      tick();
    end
    checks++;
    if (held != 5) begin
      errors++; $display("FAIL bp_hold: got %0d stable cycles want 5", held);
    end
    bus.out_ready = 1'b1;
    wait_idle(40, to);
    checks++;
    if (to || got_data.size() != nd + 2 || {got_data[nd], got_data[nd+1]} !== 16'h5C6D
        || got_addr.size() != na + 2 || {got_addr[na], got_addr[na+1]} !== 16'h3031) begin
      errors++; $display("FAIL bp_stream: timeout=%0b data %p addr %p want 5C 6D at 30 31", to, got_data, got_addr);
    end
  endtask

  task automatic test_back_to_back_start();
    int nd = got_data.size();
    int na = got_addr.size();
    bit to;
    mem[8'h50] = 8'h01; mem[8'h51] = 8'h02; mem[8'h52] = 8'h03; mem[8'h40] = 8'hEE;
    bus.out_ready = 1'b1;
    pulse_start(8'h50, 8'd3);
    tick();
    pulse_start(8'h40, 8'd2);
    tick();
    pulse_start(8'h40, 8'd2);
    wait_idle(40, to);
    checks++;
    if (to || got_addr.size() != na + 3 || {got_addr[na], got_addr[na+1], got_addr[na+2]} !== 24'h505152) begin
      errors++; $display("FAIL busy_start_addr: timeout=%0b got %p want 50 51 52", to, got_addr);
    end
    checks++;
    if (got_data.size() != nd + 3 || {got_data[nd], got_data[nd+1], got_data[nd+2]} !== 24'h010203) begin
      errors++; $display("FAIL busy_start_data: got %p want 01 02 03", got_data);
    end
  endtask

  task automatic test_reset_mid();
    int nc = done_cnt;
    int nd;
    bit to;
    mem[8'h60] = 8'h61; mem[8'h61] = 8'h62; mem[8'h62] = 8'h63; mem[8'h63] = 8'h64;
    bus.out_ready = 1'b1;
    pulse_start(8'h60, 8'd4);
    repeat (5) tick();
    checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h62}) begin
      errors++; $display("FAIL rst_mid_pre: got valid=%b data=%h want 1 62", bus.out_valid, bus.out_data);
    end
    RST_n = 1'b0; bus.start = 1'b1; bus.base = 8'h10; bus.len = 8'd1;
    tick();
    RST_n = 1'b1; bus.start = 1'b0;
    nd = got_data.size();
    checks++;
    if ({bus.out_valid, bus.done, bus.busy, bus.dram_req, bus.dram_addr, bus.out_data} !== 20'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got valid/done/busy/req=%b addr=%h data=%h want 0000 00 00",
                         {bus.out_valid, bus.done, bus.busy, bus.dram_req}, bus.dram_addr, bus.out_data);
    end
    repeat (6) tick();
    checks++;
    if (got_data.size() != nd || done_cnt != nc || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_abort: extra words=%0d done=%0d busy=%b want 0 0 0",
                         got_data.size() - nd, done_cnt - nc, bus.busy);
    end
    pulse_start(8'h10, 8'd1);
    wait_idle(20, to);
    checks++;
    if (to || got_data.size() != nd + 1 || got_data[nd] !== 8'hA1 || done_cnt != nc + 1) begin
      errors++; $display("FAIL rst_mid_restart: timeout=%0b got %p done=%0d want A1 done=1", to, got_data, done_cnt - nc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_backpressure();
    test_back_to_back_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
